// File: rtl/mips_mc_ctrl_if.sv
// Control-unit <-> datapath/memory bundle for the multi-cycle MIPS controller.
// The controller holds the master modport; the datapath and memory hold the slave modport.
interface mips_mc_ctrl_if;
    // Memory handshake: MemRead/MemWrite is a request held for as long as the
    // controller sits in an access state. mem_ready=1 in a cycle completes the
    // access on that clock edge, and the request drops in the next state.
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       mem_ready;
    logic       PcWrite;
    logic       IrWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] wd_sel;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [3:0] AluCtrl;
    logic [1:0] ExtOp;
    logic [2:0] NpcSel;
    logic       err;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, overflow, mem_ready,
        output PcWrite, IrWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, wd_sel,
               AluSrcA, AluSrcB, AluCtrl, ExtOp, NpcSel, err, state
    );

    modport slave (
        output opcode, funct, zero, overflow, mem_ready,
        input  PcWrite, IrWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, wd_sel,
               AluSrcA, AluSrcB, AluCtrl, ExtOp, NpcSel, err, state
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with a memory-wait watchdog.
// Optional MC_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module mips_mc_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_mc_ctrl_if.master       bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ERR    = 4'd15
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_LUI = 4'd4;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q;

    logic is_r, op_lw, op_sw, op_ori, op_lui, op_addi, op_beq, op_j, op_jal;
    logic fn_addu, fn_subu, fn_slt, fn_add, fn_jr, r_alu;
    logic waiting, timeout;

    assign is_r    = (bus.opcode == 6'h00);
    assign op_lw   = (bus.opcode == 6'h23);
    assign op_sw   = (bus.opcode == 6'h2B);
    assign op_ori  = (bus.opcode == 6'h0D);
    assign op_lui  = (bus.opcode == 6'h0F);
    assign op_addi = (bus.opcode == 6'h08);
    assign op_beq  = (bus.opcode == 6'h04);
    assign op_j    = (bus.opcode == 6'h02);
    assign op_jal  = (bus.opcode == 6'h03);
    assign fn_addu = is_r && (bus.funct == 6'h21);
    assign fn_subu = is_r && (bus.funct == 6'h23);
    assign fn_slt  = is_r && (bus.funct == 6'h2A);
    assign fn_add  = is_r && (bus.funct == 6'h20);
    assign fn_jr   = is_r && (bus.funct == 6'h08);
    assign r_alu   = fn_addu || fn_subu || fn_slt || fn_add;

    // The watchdog fires on the MAX_WAIT-th consecutive cycle without mem_ready.
    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                     && !bus.mem_ready;
    assign timeout = waiting && (wait_q == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_d == S_ERR) err_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus.PcWrite  = 1'b0;
        bus.IrWrite  = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IorD     = 1'b0;
        bus.RegWrite = 1'b0;
        bus.RegDst   = 2'd0;
        bus.wd_sel   = 2'd0;
        bus.AluSrcA  = 1'b0;
        bus.AluSrcB  = 2'd0;
        bus.AluCtrl  = ALU_ADD;
        bus.ExtOp    = 2'd0;
        bus.NpcSel   = 3'd0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.AluSrcB = 2'd1;
                    if (bus.mem_ready) begin
                        bus.IrWrite = 1'b1;
                        bus.PcWrite = 1'b1;
                        state_d     = S_DECODE;
                    end else if (timeout) begin
                        state_d = S_ERR;
                    end
                end
                S_DECODE: begin
                    bus.AluSrcB = 2'd3;
                    bus.ExtOp   = 2'd1;
                    if (op_lw || op_sw)                        state_d = S_MEMADR;
                    else if (r_alu || op_ori || op_lui || op_addi) state_d = S_EXEC;
                    else if (op_beq)                           state_d = S_BRANCH;
                    else if (op_j || op_jal || fn_jr)          state_d = S_JUMP;
                    else                                       state_d = S_ERR;
                end
                S_MEMADR: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluSrcB = 2'd2;
                    bus.ExtOp   = 2'd1;
                    state_d     = op_lw ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                    if (bus.mem_ready) state_d = S_MEMWB;
                    else if (timeout)  state_d = S_ERR;
                end
                S_MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.wd_sel   = 2'd1;
                    state_d      = S_FETCH;
                end
                S_MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                    if (bus.mem_ready) state_d = S_FETCH;
                    else if (timeout)  state_d = S_ERR;
                end
                S_EXEC, S_RWB: begin
                    // ALU controls stay up through RWB so overflow reflects this result.
                    if (is_r) begin
                        bus.AluSrcA = 1'b1;
                        bus.AluCtrl = fn_subu ? ALU_SUB : (fn_slt ? ALU_SLT : ALU_ADD);
                    end else if (op_ori) begin
                        bus.AluSrcA = 1'b1;
                        bus.AluSrcB = 2'd2;
                        bus.AluCtrl = ALU_OR;
                    end else if (op_lui) begin
                        bus.AluSrcB = 2'd2;
                        bus.ExtOp   = 2'd2;
                        bus.AluCtrl = ALU_LUI;
                    end else begin
                        bus.AluSrcA = 1'b1;
                        bus.AluSrcB = 2'd2;
                        bus.ExtOp   = 2'd1;
                    end
                    if (state_q == S_EXEC) begin
                        state_d = S_RWB;
                    end else begin
                        bus.RegWrite = !(bus.overflow && (fn_add || op_addi));
                        bus.RegDst   = is_r ? 2'd1 : 2'd0;
                        state_d      = S_FETCH;
                    end
                end
                S_BRANCH: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluCtrl = ALU_SUB;
                    bus.PcWrite = bus.zero;
                    bus.NpcSel  = 3'd1;
                    state_d     = S_FETCH;
                end
                S_JUMP: begin
                    bus.PcWrite = 1'b1;
                    bus.NpcSel  = fn_jr ? 3'd3 : 3'd2;
                    if (op_jal) begin
                        bus.RegWrite = 1'b1;
                        bus.RegDst   = 2'd2;
                        bus.wd_sel   = 2'd2;
                    end
                    state_d = S_FETCH;
                end
                S_ERR:   state_d = S_ERR;
                default: state_d = S_ERR;
            endcase
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) wait_d = '0;
        else if (waiting)       wait_d = wait_q + 1'b1;
    end

    assign bus.err   = err_q;
    assign bus.state = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_ERR) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if ((state_q != S_FETCH) && (state_d == S_FETCH)) instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule
